// File: rtl/psw_debounce_counter.sv
// Multi-channel push-switch front end: 2-flop synchroniser, slow-tick majority-vote
// debounce, qualified edge pulse and per-channel event counter.
module psw_debounce_counter #(
  parameter int NCH       = 4,
  parameter int TICK_DIV  = 500000,
  parameter int SMP_DEPTH = 3,
  parameter int CNT_W     = 4,
  parameter int EDGE_SEL  = 0,
  parameter int SATURATE  = 0
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [NCH-1:0]       PSW,
  input  logic [NCH-1:0]       CLR,
  output logic [NCH-1:0]       LEVEL,
  output logic [NCH-1:0]       PRESS,
  output logic [NCH*CNT_W-1:0] COUNT,
  output logic                 TICK
);

  localparam int DIV_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  logic [NCH-1:0]       sync0_q, sync0_d;
  logic [NCH-1:0]       sync1_q, sync1_d;
  logic [DIV_W-1:0]     div_q, div_d;
  logic [SMP_DEPTH-1:0] hist_q [NCH];
  logic [SMP_DEPTH-1:0] hist_d [NCH];
  logic [NCH-1:0]       level_q, level_d;
  logic [NCH-1:0]       press_q, press_d;
  logic [CNT_W-1:0]     count_q [NCH];
  logic [CNT_W-1:0]     count_d [NCH];
  logic [NCH-1:0]       maj;
  logic [NCH-1:0]       qual;

  function automatic int popcount(input logic [SMP_DEPTH-1:0] v);
    int n;
    n = 0;
    for (int k = 0; k < SMP_DEPTH; k++) begin
      if (v[k]) n++;
    end
    return n;
  endfunction

  assign TICK = (div_q == DIV_LAST);

  always_comb begin
    maj  = '0;
    qual = '0;
    for (int ch = 0; ch < NCH; ch++) begin
      maj[ch] = (popcount(hist_q[ch]) > (SMP_DEPTH / 2));
    end
    if (EDGE_SEL == 0) begin
      qual = maj & ~level_q;
    end else if (EDGE_SEL == 1) begin
      qual = ~maj & level_q;
    end else begin
      qual = maj ^ level_q;
    end
  end

  // CLR beats a qualified edge; the edge still produces its PRESS pulse.
  always_comb begin
    sync0_d = PSW;
    sync1_d = sync0_q;
    div_d   = (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
    level_d = maj;
    press_d = qual;
    for (int ch = 0; ch < NCH; ch++) begin
      hist_d[ch]  = hist_q[ch];
      count_d[ch] = count_q[ch];
      if (TICK) begin
        hist_d[ch] = {hist_q[ch][SMP_DEPTH-2:0], sync1_q[ch]};
      end
      if (CLR[ch]) begin
        count_d[ch] = '0;
      end else if (qual[ch]) begin
        if (count_q[ch] == CNT_MAX) begin
          count_d[ch] = (SATURATE != 0) ? CNT_MAX : '0;
        end else begin
          count_d[ch] = count_q[ch] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      sync0_q <= '0;
      sync1_q <= '0;
      div_q   <= '0;
      level_q <= '0;
      press_q <= '0;
      for (int ch = 0; ch < NCH; ch++) begin
        hist_q[ch]  <= '0;
        count_q[ch] <= '0;
      end
    end else begin
      sync0_q <= sync0_d;
      sync1_q <= sync1_d;
      div_q   <= div_d;
      level_q <= level_d;
      press_q <= press_d;
      for (int ch = 0; ch < NCH; ch++) begin
        hist_q[ch]  <= hist_d[ch];
        count_q[ch] <= count_d[ch];
      end
    end
  end

  assign LEVEL = level_q;
  assign PRESS = press_q;

  for (genvar g = 0; g < NCH; g++) begin : g_count
    assign COUNT[g*CNT_W +: CNT_W] = count_q[g];
  end

endmodule

// File: tb/tb_psw_debounce_counter.sv
// Bench for psw_debounce_counter: three instances (wrap, saturate, both-edge) share
// stimulus and are checked every cycle against a window-count model plus fixed expectations.
module tb_psw_debounce_counter;

  localparam int NCH  = 2;
  localparam int TD   = 4;
  localparam int SD   = 3;
  localparam int W    = 4;
  localparam int NI   = 3;
  localparam int MAXC = 15;

  localparam int ES  [NI] = '{0, 0, 2};
  localparam int SAT [NI] = '{0, 1, 0};

  logic CLK = 1'b0;
  logic RST;
  logic [NCH-1:0] PSW;
  logic [NCH-1:0] CLR;

  logic [NCH-1:0]   lv0, lv1, lv2, pr0, pr1, pr2;
  logic [NCH*W-1:0] ct0, ct1, ct2;
  logic             tk0, tk1, tk2;

  logic [NCH-1:0]   lv [NI];
  logic [NCH-1:0]   pr [NI];
  logic [NCH*W-1:0] ct [NI];
  logic             tk [NI];

  int checks   = 0;
  int failures = 0;

  always #5 CLK = ~CLK;

  psw_debounce_counter #(.NCH(NCH), .TICK_DIV(TD), .SMP_DEPTH(SD), .CNT_W(W),
    .EDGE_SEL(0), .SATURATE(0)) dut_wrap (
    .CLK(CLK), .RST(RST), .PSW(PSW), .CLR(CLR),
    .LEVEL(lv0), .PRESS(pr0), .COUNT(ct0), .TICK(tk0));

  psw_debounce_counter #(.NCH(NCH), .TICK_DIV(TD), .SMP_DEPTH(SD), .CNT_W(W),
    .EDGE_SEL(0), .SATURATE(1)) dut_sat (
    .CLK(CLK), .RST(RST), .PSW(PSW), .CLR(CLR),
    .LEVEL(lv1), .PRESS(pr1), .COUNT(ct1), .TICK(tk1));

  psw_debounce_counter #(.NCH(NCH), .TICK_DIV(TD), .SMP_DEPTH(SD), .CNT_W(W),
    .EDGE_SEL(2), .SATURATE(0)) dut_both (
    .CLK(CLK), .RST(RST), .PSW(PSW), .CLR(CLR),
    .LEVEL(lv2), .PRESS(pr2), .COUNT(ct2), .TICK(tk2));

  assign lv[0] = lv0;
  assign lv[1] = lv1;
  assign lv[2] = lv2;
  assign pr[0] = pr0;
  assign pr[1] = pr1;
  assign pr[2] = pr2;
  assign ct[0] = ct0;
  assign ct[1] = ct1;
  assign ct[2] = ct2;
  assign tk[0] = tk0;
  assign tk[1] = tk1;
  assign tk[2] = tk2;

  task automatic check_output(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0d expected=%0d time=%0t", name, act, exp, $time);
    end
  endtask

  // Reference: sync delay = PSW two edges back, tick = edges-since-reset mod TD,
  // vote = ones in a circular window of the last SD tick samples.
  bit m_valid = 1'b0;
  int cyc;
  bit pd1 [NCH];
  bit pd2 [NCH];
  bit smp [NCH][SD];
  int m_level [NI][NCH];
  int m_press [NI][NCH];
  int m_count [NI][NCH];

  always @(posedge CLK) begin
    int ones;
    bit maj, rise, fall, q;
    if (RST) begin
      m_valid = 1'b1;
      cyc = 0;
      for (int ch = 0; ch < NCH; ch++) begin
        pd1[ch] = 1'b0;
        pd2[ch] = 1'b0;
        for (int k = 0; k < SD; k++) smp[ch][k] = 1'b0;
        for (int i = 0; i < NI; i++) begin
          m_level[i][ch] = 0;
          m_press[i][ch] = 0;
          m_count[i][ch] = 0;
        end
      end
    end else if (m_valid) begin
      for (int ch = 0; ch < NCH; ch++) begin
        ones = 0;
        for (int k = 0; k < SD; k++) ones += int'(smp[ch][k]);
        maj = (2 * ones > SD);
        for (int i = 0; i < NI; i++) begin
          rise = maj && (m_level[i][ch] == 0);
          fall = !maj && (m_level[i][ch] == 1);
          q = (ES[i] == 0) ? rise : (ES[i] == 1) ? fall : (rise || fall);
          if (CLR[ch]) m_count[i][ch] = 0;
          else if (q) begin
            if (SAT[i] != 0) m_count[i][ch] = (m_count[i][ch] == MAXC) ? MAXC : m_count[i][ch] + 1;
            else m_count[i][ch] = (m_count[i][ch] + 1) % (MAXC + 1);
          end
          m_press[i][ch] = int'(q);
          m_level[i][ch] = int'(maj);
        end
        if (cyc % TD == TD - 1) smp[ch][(cyc / TD) % SD] = pd2[ch];
        pd2[ch] = pd1[ch];
        pd1[ch] = PSW[ch];
      end
      cyc++;
    end
  end

  always @(negedge CLK) begin
    if (m_valid) begin
      for (int i = 0; i < NI; i++) begin
        check_output($sformatf("d%0d_tick", i), int'(tk[i]), int'(cyc % TD == TD - 1));
        for (int ch = 0; ch < NCH; ch++) begin
          check_output($sformatf("d%0d_level%0d", i, ch), int'(lv[i][ch]), m_level[i][ch]);
          check_output($sformatf("d%0d_press%0d", i, ch), int'(pr[i][ch]), m_press[i][ch]);
          check_output($sformatf("d%0d_count%0d", i, ch), int'(ct[i][ch*W +: W]), m_count[i][ch]);
        end
      end
    end
  end

  task automatic apply_stimulus(input logic [NCH-1:0] psw, input logic [NCH-1:0] clr, input int n);
    PSW = psw;
    CLR = clr;
    repeat (n) @(negedge CLK);
  endtask

  task automatic pulse_reset();
    RST = 1'b1;
    PSW = '0;
    CLR = '0;
    repeat (2) @(negedge CLK);
    RST = 1'b0;
  endtask

  int first_tick, first_press, npress, npress_other, seen, len, total;

  initial begin
    RST = 1'b1;
    PSW = 2'b11;
    CLR = '0;
    repeat (2) @(negedge CLK);
    check_output("rst_level", int'(lv0), 0);
    check_output("rst_press", int'(pr0), 0);
    check_output("rst_count", int'(ct0), 0);
    check_output("rst_tick", int'(tk0), 0);

    RST = 1'b0;
    PSW = '0;
    first_tick = -1;
    for (int k = 1; k <= 8; k++) begin
      @(negedge CLK);
      if (tk0 && first_tick < 0) first_tick = k;
      if (k == 7) check_output("tick_period", int'(tk0), 1);
    end
    check_output("first_tick_edge", first_tick, 3);

    PSW[0] = 1'b1;
    first_press = -1;
    npress = 0;
    npress_other = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge CLK);
      if (pr0[0]) begin
        npress++;
        if (first_press < 0) first_press = k;
      end
      if (pr0[1]) npress_other++;
    end
    check_output("single_press_pulses", npress, 1);
    check_output("single_press_in_8_11", int'(first_press >= 8 && first_press <= 11), 1);
    check_output("single_count0", int'(ct0[3:0]), 1);
    check_output("single_level0", int'(lv0[0]), 1);
    check_output("single_ch1_count", int'(ct0[7:4]), 0);
    check_output("single_ch1_press", npress_other, 0);

    apply_stimulus(2'b00, 2'b00, 20);
    npress = 0;
    PSW[0] = 1'b1;
    for (int k = 0; k < 23; k++) begin
      @(negedge CLK);
      if (k == 2) PSW[0] = 1'b0;
      if (pr0[0]) npress++;
    end
    check_output("glitch_press", npress, 0);
    check_output("glitch_level", int'(lv0[0]), 0);
    check_output("glitch_count", int'(ct0[3:0]), 1);

    pulse_reset();
    for (int p = 0; p < 17; p++) begin
      apply_stimulus(2'b10, 2'b00, 12);
      apply_stimulus(2'b00, 2'b00, 12);
    end
    apply_stimulus(2'b00, 2'b00, 12);
    check_output("wrap_count1", int'(ct0[7:4]), 1);
    check_output("sat_count1", int'(ct1[7:4]), 15);
    check_output("both_count1", int'(ct2[7:4]), 2);

    pulse_reset();
    npress = 0;
    PSW = 2'b01;
    for (int k = 0; k < 32; k++) begin
      @(negedge CLK);
      if (k == 15) PSW = 2'b00;
      if (pr2[0]) npress++;
    end
    check_output("both_edge_pulses", npress, 2);
    check_output("both_edge_count0", int'(ct2[3:0]), 2);
    check_output("rise_only_count0", int'(ct0[3:0]), 1);

    seen = 0;
    CLR = 2'b01;
    PSW = 2'b01;
    for (int k = 0; k < 16; k++) begin
      @(negedge CLK);
      if (pr2[0]) seen++;
    end
    check_output("clr_edge_press", seen, 1);
    check_output("clr_edge_count0", int'(ct2[3:0]), 0);
    CLR = '0;
    apply_stimulus(2'b00, 2'b00, 16);

    pulse_reset();
    npress = 0;
    PSW = 2'b01;
    repeat (5) begin
      @(negedge CLK);
      if (pr0[0]) npress++;
    end
    RST = 1'b1;
    @(negedge CLK);
    if (pr0[0]) npress++;
    RST = 1'b0;
    first_press = -1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge CLK);
      if (pr0[0] && first_press < 0) first_press = k;
    end
    check_output("mid_rst_no_early_press", npress, 0);
    check_output("mid_rst_latency_8_11", int'(first_press >= 8 && first_press <= 11), 1);

    pulse_reset();
    total = 0;
    while (total < 2500) begin
      len = $urandom_range(1, 14);
      PSW = NCH'($urandom_range(0, 3));
      for (int k = 0; k < len; k++) begin
        CLR = ($urandom_range(0, 15) == 0) ? NCH'($urandom_range(1, 3)) : '0;
        RST = ($urandom_range(0, 499) == 0);
        @(negedge CLK);
      end
      total += len;
    end
    RST = 1'b0;
    CLR = '0;
    repeat (4) @(negedge CLK);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
